// File: rtl/memShare_pkg.sv
// Shared types and defaults for the memShare request path.
package memShare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } rqst_seq_state_t;

  localparam int MEMSHARE_FB_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/memShare_lsb_isolate.sv
// One-hot lowest set bit of a vector, plus a flag for the all-zero case.
module memShare_lsb_isolate #(
  parameter int W = 5
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] lsb,
  output logic         none
);

  assign lsb  = vec & (~vec + W'(1));
  assign none = (vec == '0);

endmodule

// File: rtl/memshare_rqst_seq.sv
// Request sequencer in front of the RFMU: feeds residual flags, waits out the
// feedback latency, emits one shift command per pass and retires the lowest request.
module memshare_rqst_seq
  import memShare_pkg::*;
#(
  parameter int RQST_BITWIDTH       = 5,
  parameter int L1PA_SHIFT_BITWIDTH = $clog2(RQST_BITWIDTH),
  parameter int FB_LATENCY          = MEMSHARE_FB_LATENCY_DEFAULT
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           rqst_valid_i,
  input  logic [RQST_BITWIDTH-1:0]       rqst_flag_i,
  output logic                           rqst_ready_o,
  input  logic                           flush_i,
  output logic [RQST_BITWIDTH-1:0]       rqstFlag_o,
  input  logic [L1PA_SHIFT_BITWIDTH-1:0] l1pa_shift_i,
  input  logic                           isGtr_i,
  output logic [L1PA_SHIFT_BITWIDTH-1:0] l1pa_shift_o,
  output logic                           l1pa_shift_valid_o,
  output logic [RQST_BITWIDTH-1:0]       served_mask_o,
  output logic                           done_o,
  output logic                           busy_o
);

  localparam int CW = (FB_LATENCY > 1) ? $clog2(FB_LATENCY) : 1;
  localparam logic [CW-1:0] WLOAD = CW'(FB_LATENCY - 1);

  rqst_seq_state_t          state;
  logic [CW-1:0]            wcnt;
  logic [RQST_BITWIDTH-1:0] residual, iso_in, lsb, remain;
  logic                     iso_none;

  // In IDLE the isolator looks at the incoming vector to spot an empty request;
  // otherwise it works on the residual.
  assign iso_in = (state == IDLE) ? rqst_flag_i : residual;

  memShare_lsb_isolate #(.W(RQST_BITWIDTH)) u_lsb (
    .vec  (iso_in),
    .lsb  (lsb),
    .none (iso_none)
  );

  assign remain       = residual & ~lsb;
  assign rqstFlag_o   = residual;
  assign rqst_ready_o = (state == IDLE);
  assign busy_o       = (state != IDLE);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      wcnt               <= '0;
      residual           <= '0;
      l1pa_shift_o       <= '0;
      l1pa_shift_valid_o <= 1'b0;
      served_mask_o      <= '0;
      done_o             <= 1'b0;
    end else begin
      l1pa_shift_valid_o <= 1'b0;
      done_o             <= 1'b0;
      if (flush_i) begin
        state    <= IDLE;
        residual <= '0;
        wcnt     <= '0;
      end else begin
        case (state)
          IDLE: if (rqst_valid_i) begin
            if (iso_none) begin
              done_o <= 1'b1;
            end else begin
              residual <= rqst_flag_i;
              wcnt     <= WLOAD;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (wcnt == '0) state <= EMIT;
            else            wcnt  <= wcnt - CW'(1);
          end
          EMIT: begin
            l1pa_shift_o       <= l1pa_shift_i;
            served_mask_o      <= lsb;
            l1pa_shift_valid_o <= 1'b1;
            // Each pass clears one bit, so the loop is bounded by popcount.
            if (isGtr_i || (remain == '0)) begin
              done_o   <= 1'b1;
              residual <= '0;
              state    <= IDLE;
            end else begin
              residual <= remain;
              wcnt     <= WLOAD;
              state    <= WAIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
